// File: rtl/bus_transfer_sequencer_if.sv
// Request handshake and one-hot bus control bundle for bus_transfer_sequencer.
// master: the requester side; slave: the sequencer side.
interface bus_transfer_sequencer_if #(
    parameter int REGISTERS = 22,
    parameter int IDX_W     = 5,
    parameter int DEPTH     = 4
);
    logic                   req_valid;
    logic                   req_ready;
    logic [IDX_W-1:0]       req_src;
    logic [IDX_W-1:0]       req_dst;
    logic [REGISTERS-1:0]   registerSelect;
    logic [REGISTERS-1:0]   regLoad;
    logic                   xfer_done;
    logic                   xfer_err;
    logic                   busy;
    logic [$clog2(DEPTH):0] q_count;

    modport master (
        output req_valid, req_src, req_dst,
        input  req_ready, registerSelect, regLoad, xfer_done, xfer_err, busy, q_count
    );

    modport slave (
        input  req_valid, req_src, req_dst,
        output req_ready, registerSelect, regLoad, xfer_done, xfer_err, busy, q_count
    );
endinterface

// File: rtl/bus_transfer_sequencer.sv
// bus_transfer_sequencer: queues register-to-register transfer requests and
// drives the bus mux source select and destination load enable in a fixed
// DRIVE/LATCH sequence so that at most one source ever drives the bus.
// Optional macro BUS_XFER_STATS_EN adds xfer_count / err_count outputs.
//
// state | meaning
// IDLE  | no transfer in flight; pops the queue head when one is present
// DRIVE | source selected onto the bus, no load yet
// LATCH | source still selected, destination load enable and done pulse
module bus_transfer_sequencer #(
    parameter int BITS      = 32,
    parameter int REGISTERS = 22,
    parameter int IDX_W     = 5,
    parameter int DEPTH     = 4
) (
    input logic clk,
    input logic clr,
    bus_transfer_sequencer_if.slave bus
`ifdef BUS_XFER_STATS_EN
    ,
    output logic [31:0] xfer_count,
    output logic [15:0] err_count
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]     FULL_CNT = CNT_W'(DEPTH);
    localparam logic [IDX_W:0]       REG_LIM  = (IDX_W + 1)'(REGISTERS);
    localparam logic [REGISTERS-1:0] ONE_LSB  = REGISTERS'(1);

    // The bus width is carried only so the parameter set matches the datapath.
    if (BITS < 1 || DEPTH < 2 || (2 ** IDX_W) < REGISTERS) begin : gBadParams
        $error("bus_transfer_sequencer: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, DRIVE, LATCH} stateType;

    stateType             state, nextState;
    logic [IDX_W-1:0]     srcMem [DEPTH];
    logic [IDX_W-1:0]     dstMem [DEPTH];
    logic [PTR_W-1:0]     wrPtr, rdPtr;
    logic [CNT_W-1:0]     count, countNext;
    logic [IDX_W-1:0]     curSrc, curDst, nextSrc, nextDst;
    logic [REGISTERS-1:0] selReg, loadReg, nextSel, nextLoad;
    logic                 doneReg, errReg, nextDone, nextErr;
    logic                 readyReg, busyReg;
    logic                 push, pop, headOk;
    logic [IDX_W-1:0]     headSrc, headDst;

    assign push    = bus.req_valid && readyReg;
    assign headSrc = srcMem[rdPtr];
    assign headDst = dstMem[rdPtr];
    assign headOk  = ({1'b0, headSrc} < REG_LIM) && ({1'b0, headDst} < REG_LIM)
                     && (headSrc != headDst);

    // Next-state, pop decision and next registered control outputs.
    always_comb begin
        nextState = state;
        pop       = 1'b0;
        nextSrc   = curSrc;
        nextDst   = curDst;
        nextSel   = '0;
        nextLoad  = '0;
        nextDone  = 1'b0;
        nextErr   = 1'b0;
        case (state)
            DRIVE: begin
                nextState = LATCH;
                nextSel   = ONE_LSB << curSrc;
                nextLoad  = ONE_LSB << curDst;
                nextDone  = 1'b1;
            end
            IDLE, LATCH: begin
                nextState = IDLE;
                if (count != '0) begin
                    pop = 1'b1;
                    if (headOk) begin
                        nextState = DRIVE;
                        nextSrc   = headSrc;
                        nextDst   = headDst;
                        nextSel   = ONE_LSB << headSrc;
                    end else begin
                        nextErr = 1'b1;
                    end
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Occupancy after this edge's push/pop.
    always_comb begin
        countNext = count;
        case ({push, pop})
            2'b10:   countNext = count + 1'b1;
            2'b01:   countNext = count - 1'b1;
            default: countNext = count;
        endcase
    end

    // Queue storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            srcMem[wrPtr] <= bus.req_src;
            dstMem[wrPtr] <= bus.req_dst;
        end
    end

    // State, queue pointers and all registered outputs.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state    <= IDLE;
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            curSrc   <= '0;
            curDst   <= '0;
            selReg   <= '0;
            loadReg  <= '0;
            doneReg  <= 1'b0;
            errReg   <= 1'b0;
            readyReg <= 1'b1;
            busyReg  <= 1'b0;
        end else begin
            state    <= nextState;
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            count    <= countNext;
            curSrc   <= nextSrc;
            curDst   <= nextDst;
            selReg   <= nextSel;
            loadReg  <= nextLoad;
            doneReg  <= nextDone;
            errReg   <= nextErr;
            readyReg <= (countNext != FULL_CNT);
            busyReg  <= (nextState != IDLE) || (countNext != '0);
        end
    end

    assign bus.req_ready      = readyReg;
    assign bus.registerSelect = selReg;
    assign bus.regLoad        = loadReg;
    assign bus.xfer_done      = doneReg;
    assign bus.xfer_err       = errReg;
    assign bus.busy           = busyReg;
    assign bus.q_count        = count;

`ifdef BUS_XFER_STATS_EN
    // Transfer counter wraps; error counter saturates.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            xfer_count <= '0;
            err_count  <= '0;
        end else begin
            if (nextDone) xfer_count <= xfer_count + 1'b1;
            if (nextErr && (err_count != 16'hFFFF)) err_count <= err_count + 1'b1;
        end
    end
`endif
endmodule

// File: doc/bus_transfer_sequencer.md
Name: bus_transfer_sequencer

Overview:
Control-side stage directly upstream of the register-select bus mux. Accepts queued register-to-register transfer requests (source index, destination index). Drives the mux's one-hot source select and the one-hot destination load enable in a fixed two-cycle drive/latch sequence. Guarantees at most one bus driver at any time, so the tri-state bus never sees contention.

Parameters:
BITS, 32, bus data width; informational only, no datapath inside this block
REGISTERS, 22, number of selectable sources/destinations; width of one-hot select and load vectors
IDX_W, 5, width of source/destination index fields; must satisfy 2**IDX_W >= REGISTERS
DEPTH, 4, request queue depth; power of two, minimum 2

Ports:
clk  input  1  system clock, rising edge
clr  input  1  asynchronous reset, active-low
req_valid  input  1  request present on req_src/req_dst
req_ready  output  1  queue can accept a request this cycle
req_src  input  IDX_W  source register index
req_dst  input  IDX_W  destination register index
registerSelect  output  REGISTERS  one-hot source select to bus mux
regLoad  output  REGISTERS  one-hot destination load enable
xfer_done  output  1  one-cycle pulse, transfer latched
xfer_err  output  1  one-cycle pulse, request rejected
busy  output  1  sequencer not IDLE or queue non-empty
q_count  output  $clog2(DEPTH)+1  current queue occupancy

Behaviour:
- Reset (clr low, asynchronous):
  - All outputs 0, except req_ready = 1.
  - Queue emptied; FSM to IDLE.
  - Applies mid-transfer: registerSelect/regLoad drop immediately; the in-flight transfer is lost and no done/err pulse is issued.
- Enqueue: a push occurs on a rising edge with req_valid && req_ready.
  - req_ready = !full, registered from occupancy.
  - No push when full, even if a pop happens the same cycle.
- Validation at pop time: if src >= REGISTERS or dst >= REGISTERS or src == dst:
  - Entry discarded.
  - xfer_err pulses for 1 cycle.
  - Selects stay 0 and the FSM stays IDLE (or continues to the next entry on the following cycle).
- FSM states:
  - IDLE: if queue non-empty, pop head.
    - Valid head -> DRIVE.
    - Invalid head -> IDLE, with xfer_err pulse.
  - DRIVE (1 cycle): registerSelect = 1<<src; regLoad = 0. Next state is LATCH.
  - LATCH (1 cycle): registerSelect held = 1<<src; regLoad = 1<<dst; xfer_done = 1.
    - If queue non-empty, pop head and go to DRIVE directly when valid; go to IDLE with xfer_err when invalid.
    - Otherwise go to IDLE.
- All control outputs are registered; they change only on clk edges or on async clr.
- Latency, empty queue and idle FSM:
  - Push on edge N.
  - DRIVE outputs visible after edge N+1.
  - LATCH outputs and xfer_done visible after edge N+2.
- Throughput: back-to-back valid requests complete one per 2 cycles.
- Invariants:
  - popcount(registerSelect) <= 1 at all times.
  - popcount(regLoad) <= 1 at all times.
  - regLoad is non-zero only while registerSelect is non-zero.
  - regLoad never equals registerSelect.
- Simultaneous push and pop: allowed when not full; q_count is unchanged.
- Queue pointers wrap modulo DEPTH. The full/empty distinction comes from the count, not from pointer equality.
- busy = (state != IDLE) || (q_count != 0).

Optional Feature:
Macro BUS_XFER_STATS_EN.
- Defined:
  - Adds output port xfer_count (32 bits) counting xfer_done pulses, wrapping at 2**32.
  - Adds output port err_count (16 bits) counting xfer_err pulses, saturating at 16'hFFFF.
  - Both counters clear on clr.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset then single request src=3, dst=7 at edge 1:
  - registerSelect=0x000008 after edge 2.
  - regLoad=0x000080 and xfer_done=1 after edge 3.
  - All zero after edge 4.
- Push 4 requests (1->2, 2->3, 3->4, 4->5) in consecutive cycles:
  - req_ready=0 while q_count=4.
  - Four xfer_done pulses spaced exactly 2 cycles apart.
  - Popcount of each select/load vector never exceeds 1.
- Requests src=22 dst=1, src=5 dst=5, src=0 dst=21:
  - Two xfer_err pulses; no select asserted for those entries.
  - Third request gives registerSelect=0x000001, then regLoad=0x200000.
- Assert clr low during LATCH of 6->9 with 2 entries queued:
  - Outputs 0 immediately, before the next clk edge.
  - q_count=0 and busy=0; no done pulse after release.
- With q_count=3, push and pop in the same cycle: q_count stays 3 and req_ready stays 1. Fill to 4 with a same-cycle pop: push refused.
- With BUS_XFER_STATS_EN: 5 good and 2 bad requests -> xfer_count=5, err_count=2; both 0 after clr.
